// File: rtl/scrambler_pkg.sv
// Shared constants and the beat-level scrambling function for the RIFL lane
// scrambler; widths are bounded by MAX_DWIDTH / MAX_N2.
package scrambler_pkg;

    localparam int DEF_N1     = 13;
    localparam int DEF_N2     = 33;
    localparam int MAX_DWIDTH = 128;
    localparam int MAX_N2     = 64;

    typedef logic [MAX_N2-1:0]     state_t;
    typedef logic [MAX_DWIDTH-1:0] beat_t;

    typedef struct packed {
        beat_t  processed;
        state_t next_state;
    } beat_result_t;

    // W = {state, L}; bit dwidth-1 is earliest in time, so walking i downward
    // resolves the recursive scrambler taps before they are needed.
    function automatic beat_result_t scramble_beat(
        input state_t state,
        input beat_t  data,
        input logic   direction,
        input int     dwidth,
        input int     n1,
        input int     n2
    );
        logic [MAX_N2+MAX_DWIDTH-1:0] w;
        beat_result_t                 res;
        w   = '0;
        res = '0;
        for (int j = 0; j < MAX_N2; j++) begin
            if (j < n2) w[j + dwidth] = state[j];
        end
        for (int i = MAX_DWIDTH - 1; i >= 0; i--) begin
            if (i < dwidth) begin
                res.processed[i] = data[i] ^ w[i + n1] ^ w[i + n2];
                w[i]             = direction ? data[i] : res.processed[i];
            end
        end
        for (int j = 0; j < MAX_N2; j++) begin
            if (j < n2) res.next_state[j] = w[j];
        end
        return res;
    endfunction

endpackage

// File: rtl/scrambler_pipe_if.sv
// Beat stream of the scrambler: input handshake with bypass sideband, and the
// registered output handshake. slave is the scrambler side.
interface scrambler_pipe_if #(
    parameter int DWIDTH = 64
);
    logic [DWIDTH-1:0] in_data;
    logic              in_bypass;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_bypass, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_bypass, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/scrambler_core.sv
// Combinational beat computation: processed data and next history for one beat.
// direction=1 takes history from the input (descramble, also used for bypass).
module scrambler_core
    import scrambler_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int N1     = DEF_N1,
    parameter int N2     = DEF_N2
) (
    input  logic [N2-1:0]     state,
    input  logic [DWIDTH-1:0] data,
    input  logic              direction,
    output logic [DWIDTH-1:0] processed,
    output logic [N2-1:0]     next_state
);

    state_t       state_ext;
    beat_t        data_ext;
    beat_result_t res;
    logic         unused_res;

    // NOTE: every variable gets a full default before partial writes, so no latch is inferred.
    always_comb begin
        state_ext             = '0;
        state_ext[N2-1:0]     = state;
        data_ext              = '0;
        data_ext[DWIDTH-1:0]  = data;
        res                   = scramble_beat(state_ext, data_ext, direction, DWIDTH, N1, N2);
    end

    assign processed  = res.processed[DWIDTH-1:0];
    assign next_state = res.next_state[N2-1:0];
    assign unused_res = ^res;

endmodule

// File: rtl/scrambler_pipe.sv
// Flow-controlled self-synchronous scrambler/descrambler with one output
// register stage, seed/flush, per-beat bypass and a sync indicator.
module scrambler_pipe
    import scrambler_pkg::*;
#(
    parameter int            DWIDTH    = 64,
    parameter int            N1        = DEF_N1,
    parameter int            N2        = DEF_N2,
    parameter logic          DIRECTION = 1'b0,
    parameter logic [N2-1:0] SEED      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    scrambler_pipe_if.slave   bus,
    output logic              sync_done
);

    localparam int              SYNC_BEATS = (N2 + DWIDTH - 1) / DWIDTH;
    localparam int              CNT_W      = $clog2(SYNC_BEATS + 1);
    localparam logic [CNT_W-1:0] SYNC_MAX  = CNT_W'(SYNC_BEATS);

    logic [N2-1:0]     state;
    logic [N2-1:0]     core_next;
    logic [DWIDTH-1:0] core_proc;
    logic [DWIDTH-1:0] processed;
    logic [CNT_W-1:0]  count;
    logic              accept;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // Bypass beats still feed history, taken from the raw input like a descrambler.
    scrambler_core #(
        .DWIDTH (DWIDTH),
        .N1     (N1),
        .N2     (N2)
    ) u_core (
        .state      (state),
        .data       (bus.in_data),
        .direction  (DIRECTION | bus.in_bypass),
        .processed  (core_proc),
        .next_state (core_next)
    );

    assign processed = bus.in_bypass ? bus.in_data : core_proc;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
            count <= '0;
        end else if (flush) begin
            state <= SEED;
            count <= '0;
        end else if (accept) begin
            state <= core_next;
            if (count != SYNC_MAX) count <= count + 1'b1;
        end
    end

    // NOTE: out_data is a single register, not a memory, so it is reset to a known zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= processed;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    assign sync_done = (count >= SYNC_MAX);

endmodule
